// File: rtl/bsn_pkg.sv
// bsn_pkg: shared widths, sideband entry, controller states and lane reversal for the BSN stream controller.
package bsn_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int N_INPUTS = 8;
  localparam int LATENCY = 6;
  localparam int TAG_W = 4;
  localparam int VEC_W = DATA_WIDTH * N_INPUTS;
  typedef struct packed {
    logic v;
    logic desc;
    logic [TAG_W-1:0] tag;
  } sb_t;
  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;
  function automatic logic [VEC_W-1:0] lane_reverse(input logic [VEC_W-1:0] x);
    logic [VEC_W-1:0] r;
    for (int i = 0; i < N_INPUTS; i++)
      r[i*DATA_WIDTH +: DATA_WIDTH] = x[(N_INPUTS-1-i)*DATA_WIDTH +: DATA_WIDTH];
    return r;
  endfunction
endpackage

// File: rtl/bsn_stream_ctrl_sideband.sv
// bsn_sideband_pipe: enable-gated shift register of sideband entries kept in step with the BSN stages.
module bsn_sideband_pipe
  import bsn_pkg::*;
#(
  parameter int LATENCY = bsn_pkg::LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  sb_t  din,
  output sb_t  dout,
  output logic any_v
);
  sb_t sb_q [LATENCY];
  sb_t sb_d [LATENCY];
  always_comb begin
    sb_d[0] = en ? din : sb_q[0];
    for (int k = 1; k < LATENCY; k++) sb_d[k] = en ? sb_q[k-1] : sb_q[k];
    any_v = 1'b0;
    for (int k = 0; k < LATENCY; k++) any_v = any_v | sb_q[k].v;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) sb_q[k] <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end
  assign dout = sb_q[LATENCY-1];
endmodule

// File: rtl/bsn_stream_ctrl.sv
// bsn_stream_ctrl: valid/ready wrapper around an external pipelined BSN with stall, sideband, flush and job counter.
// Element width, lane count and tag width come from bsn_pkg.
module bsn_stream_ctrl
  import bsn_pkg::*;
#(
  parameter int LATENCY = bsn_pkg::LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [VEC_W-1:0] s_data,
  input  logic             s_desc,
  input  logic [TAG_W-1:0] s_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [VEC_W-1:0] m_data,
  output logic [TAG_W-1:0] m_tag,
  output logic             bsn_en,
  output logic [VEC_W-1:0] bsn_data_in,
  input  logic [VEC_W-1:0] bsn_data_out,
  input  logic             flush,
  output logic             busy,
  output logic             flush_done,
  output logic [15:0]      done_cnt
);
  state_t           state_q, state_d;
  logic             m_valid_q, m_valid_d;
  logic [VEC_W-1:0] m_data_q, m_data_d;
  logic [TAG_W-1:0] m_tag_q, m_tag_d;
  logic [15:0]      done_cnt_q, done_cnt_d;
  logic             adv, accept, any_v;
  sb_t              sb_in, sb_out;
  bsn_sideband_pipe #(.LATENCY(LATENCY)) u_sb (
    .clk(clk), .rst(rst), .en(adv), .din(sb_in), .dout(sb_out), .any_v(any_v)
  );
  // The whole pipeline stalls only when a held result is not being taken.
  always_comb begin
    adv = !m_valid_q | m_ready;
    s_ready = adv & (state_q == RUN);
    accept = s_valid & s_ready;
    sb_in = '{v: accept, desc: s_desc, tag: s_tag};
    m_valid_d = adv ? sb_out.v : m_valid_q;
    m_tag_d = adv ? sb_out.tag : m_tag_q;
    m_data_d = adv ? (sb_out.desc ? lane_reverse(bsn_data_out) : bsn_data_out) : m_data_q;
    busy = m_valid_q | any_v;
    state_d = (state_q == RUN) ? (flush ? DRAIN : RUN) : (busy ? DRAIN : RUN);
    flush_done = (state_q == DRAIN) & !busy;
    done_cnt_d = done_cnt_q + 16'(m_valid_q & m_ready);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      m_tag_q <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      m_tag_q <= m_tag_d;
      done_cnt_q <= done_cnt_d;
    end
  end
  assign bsn_en = adv;
  assign bsn_data_in = s_data;
  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign m_tag = m_tag_q;
  assign done_cnt = done_cnt_q;
endmodule

// File: tb/tb_bsn_stream_ctrl.sv
// tb_bsn_stream_ctrl: scoreboard bench for bsn_stream_ctrl with a behavioural 6-stage sorting network beside it.
module tb_bsn_stream_ctrl;
  import bsn_pkg::*;
  logic clk = 1'b0;
  logic rst, s_valid, s_ready, s_desc, m_valid, m_ready, bsn_en, flush, busy, flush_done;
  logic [VEC_W-1:0] s_data, m_data, bsn_data_in, bsn_data_out;
  logic [TAG_W-1:0] s_tag, m_tag;
  logic [15:0] done_cnt;
  always #5 clk = ~clk;
  bsn_stream_ctrl dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_desc(s_desc), .s_tag(s_tag), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_tag(m_tag), .bsn_en(bsn_en), .bsn_data_in(bsn_data_in),
    .bsn_data_out(bsn_data_out), .flush(flush), .busy(busy),
    .flush_done(flush_done), .done_cnt(done_cnt)
  );
  function automatic logic [VEC_W-1:0] sorted(input logic [VEC_W-1:0] d, input logic desc);
    logic [DATA_WIDTH-1:0] a [N_INPUTS];
    logic [DATA_WIDTH-1:0] t;
    logic [VEC_W-1:0] r;
    for (int i = 0; i < N_INPUTS; i++) a[i] = d[i*DATA_WIDTH +: DATA_WIDTH];
    for (int i = 0; i < N_INPUTS; i++)
      for (int j = 0; j < N_INPUTS - 1 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int i = 0; i < N_INPUTS; i++)
      r[i*DATA_WIDTH +: DATA_WIDTH] = desc ? a[N_INPUTS-1-i] : a[i];
    return r;
  endfunction
  logic [VEC_W-1:0] stage [6];
  assign bsn_data_out = stage[5];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 6; k++) stage[k] <= '0;
    end else if (bsn_en) begin
      stage[0] <= sorted(bsn_data_in, 1'b0);
      for (int k = 1; k < 6; k++) stage[k] <= stage[k-1];
    end
  end
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [VEC_W-1:0] data;
  } exp_t;
  exp_t exp_q [$];
  int vec = 0, miss = 0, hs = 0, run_len = 0, max_run = 0;
  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] r;
    for (int i = 0; i < N_INPUTS; i++) r[i*DATA_WIDTH +: DATA_WIDTH] = $urandom;
    return r;
  endfunction
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) run_len = 0;
      else begin
        if (s_valid && s_ready) exp_q.push_back('{tag: s_tag, data: sorted(s_data, s_desc)});
        if (m_valid && m_ready) begin
          hs++; run_len++; vec++;
          if (run_len > max_run) max_run = run_len;
          if (exp_q.size() == 0) begin
            miss++;
            $display("FAIL out_unexpected: got tag=%0d data=%h, required no output", m_tag, m_data);
          end else begin
            e = exp_q.pop_front();
            if (m_tag !== e.tag || m_data !== e.data) begin
              miss++;
              $display("FAIL out_vec: got tag=%0d data=%h, required tag=%0d data=%h", m_tag, m_data, e.tag, e.data);
            end
          end
        end else run_len = 0;
      end
    end
  endtask
  task automatic send(input logic [VEC_W-1:0] d, input logic desc, input logic [TAG_W-1:0] tag, output int waits);
    s_valid = 1'b1; s_data = d; s_desc = desc; s_tag = tag; waits = 0;
    @(negedge clk);
    while (!s_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask
  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    vec++;
    if (n >= 500) begin
      miss++;
      $display("FAIL drain_timeout: got %0d pending after %0d cycles, required 0", exp_q.size(), n);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_desc = 1'b0; s_tag = '0; m_ready = 1'b1; flush = 1'b0;
    #1;
    vec++;
    if ({s_ready, bsn_en, m_valid, busy, flush_done} !== 5'b11000) begin
      miss++;
      $display("FAIL reset_ctl: got rdy/en/mv/busy/fd=%b, required 11000", {s_ready, bsn_en, m_valid, busy, flush_done});
    end
    vec++;
    if (done_cnt !== 16'h0 || m_tag !== '0 || m_data !== '0) begin
      miss++;
      $display("FAIL reset_regs: got cnt=%h tag=%h data=%h, required zeros", done_cnt, m_tag, m_data);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_single();
    logic [VEC_W-1:0] in_v, want;
    int cyc = 0;
    in_v = {32'd3, 32'd8, 32'd1, 32'd6, 32'd2, 32'd7, 32'd4, 32'd5};
    want = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    s_valid = 1'b1; s_data = in_v; s_desc = 1'b0; s_tag = 4'd5;
    while (!m_valid && cyc < 20) begin
      @(posedge clk); #1;
      s_valid = 1'b0;
      cyc++;
    end
    vec++;
    if (cyc !== 7) begin
      miss++;
      $display("FAIL single_latency: got %0d cycles, required 7", cyc);
    end
    vec++;
    if (m_data !== want || m_tag !== 4'd5) begin
      miss++;
      $display("FAIL single_data: got tag=%0d data=%h, required tag=5 data=%h", m_tag, m_data, want);
    end
    @(posedge clk); #1;
    vec++;
    if (done_cnt !== 16'd1 || m_valid !== 1'b0) begin
      miss++;
      $display("FAIL single_count: got cnt=%0d mv=%b, required cnt=1 mv=0", done_cnt, m_valid);
    end
  endtask
  task automatic test_desc();
    logic [VEC_W-1:0] want;
    int cyc = 0;
    want = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    s_valid = 1'b1; s_data = {32'd3, 32'd8, 32'd1, 32'd6, 32'd2, 32'd7, 32'd4, 32'd5}; s_desc = 1'b1; s_tag = 4'd6;
    while (!m_valid && cyc < 20) begin
      @(posedge clk); #1;
      s_valid = 1'b0;
      cyc++;
    end
    vec++;
    if (m_data !== want || m_tag !== 4'd6) begin
      miss++;
      $display("FAIL desc_data: got tag=%0d data=%h, required tag=6 data=%h", m_tag, m_data, want);
    end
    wait_drain();
  endtask
  task automatic test_stream();
    int w;
    max_run = 0;
    for (int t = 0; t < 8; t++) begin
      send(rand_vec(), 1'($urandom), TAG_W'(t), w);
      vec++;
      if (w !== 0) begin
        miss++;
        $display("FAIL stream_ready: vector %0d got %0d wait cycles, required 0", t, w);
      end
    end
    wait_drain();
    vec++;
    if (max_run !== 8) begin
      miss++;
      $display("FAIL stream_run: got %0d consecutive outputs, required 8", max_run);
    end
  endtask
  task automatic test_backpressure();
    fork
      begin
        int w;
        for (int t = 8; t < 20; t++) send(rand_vec(), 1'($urandom), TAG_W'(t), w);
      end
      begin
        logic [VEC_W-1:0] sd;
        logic [TAG_W-1:0] st;
        repeat (10) @(posedge clk);
        #1 m_ready = 1'b0;
        sd = m_data; st = m_tag;
        for (int i = 0; i < 5; i++) begin
          #1;
          vec++;
          if (bsn_en !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b1) begin
            miss++;
            $display("FAIL stall_ctl: cycle %0d got en=%b rdy=%b mv=%b, required 0 0 1", i, bsn_en, s_ready, m_valid);
          end
          vec++;
          if (m_data !== sd || m_tag !== st) begin
            miss++;
            $display("FAIL stall_hold: cycle %0d got tag=%0d data=%h, required tag=%0d data=%h", i, m_tag, m_data, st, sd);
          end
          @(posedge clk); #1;
        end
        m_ready = 1'b1;
      end
    join
    wait_drain();
  endtask
  task automatic test_flush();
    int w, fd = 0, blocked_err = 0, hs0, hs_fd = -1;
    for (int t = 1; t < 4; t++) send(rand_vec(), 1'($urandom), TAG_W'(t), w);
    hs0 = hs;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (flush_done) begin
        fd++;
        hs_fd = hs - hs0;
      end
      if (fd == 0 && s_ready) blocked_err++;
      @(posedge clk); #1;
    end
    vec++;
    if (fd !== 1 || blocked_err !== 0) begin
      miss++;
      $display("FAIL flush_pulse: got %0d pulses, %0d ready cycles while draining, required 1 and 0", fd, blocked_err);
    end
    vec++;
    if (hs_fd !== 3 || busy !== 1'b0) begin
      miss++;
      $display("FAIL flush_drain: got %0d results before done busy=%b, required 3 busy=0", hs_fd, busy);
    end
    send(rand_vec(), 1'b0, 4'd9, w);
    vec++;
    if (w !== 0) begin
      miss++;
      $display("FAIL flush_resume: got %0d wait cycles, required 0", w);
    end
    wait_drain();
  endtask
  task automatic test_reset_mid();
    int w, stale = 0;
    for (int t = 10; t < 14; t++) send(rand_vec(), 1'($urandom), TAG_W'(t), w);
    rst = 1'b1;
    #1;
    vec++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== 16'h0 || s_ready !== 1'b1) begin
      miss++;
      $display("FAIL rst_mid: got mv=%b busy=%b cnt=%0d rdy=%b, required 0 0 0 1", m_valid, busy, done_cnt, s_ready);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (m_valid) stale++;
    end
    vec++;
    if (stale !== 0) begin
      miss++;
      $display("FAIL rst_stale: got %0d stale output cycles, required 0", stale);
    end
  endtask
  task automatic test_wrap();
    int w;
    for (int n = 0; n < 65535; n++) send(rand_vec(), 1'($urandom), TAG_W'(n), w);
    wait_drain();
    vec++;
    if (done_cnt !== 16'hFFFF) begin
      miss++;
      $display("FAIL wrap_top: got %h, required ffff", done_cnt);
    end
    send(rand_vec(), 1'b0, 4'd0, w);
    wait_drain();
    vec++;
    if (done_cnt !== 16'h0000) begin
      miss++;
      $display("FAIL wrap_zero: got %h, required 0000", done_cnt);
    end
  endtask
  initial begin
    test_reset();
    fork
      monitor();
    join_none
    test_single();
    test_desc();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/bsn_stream_ctrl.md
Name: bsn_stream_ctrl

Overview:
- Valid/ready stream controller wrapped around one pipelined BSN instance (DATA_WIDTH 32, N_INPUTS 8).
- Admits one vector per cycle and drives the BSN enable as a pipeline-wide stall.
- Carries per-vector sideband (valid, descending flag, tag) alongside the BSN stages, applies lane reversal for descending sorts, and presents results on a registered output stage.
- Provides a flush/drain sequence and a completed-job counter.

Parameters:
- DATA_WIDTH, 32, bits per element
- N_INPUTS, 8, elements per vector (power of 2)
- LATENCY, 6, BSN register stages between bsn_data_in and bsn_data_out; each advances only when bsn_en=1
- TAG_W, 4, width of the job tag carried with each vector

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  input vector valid
- s_ready  out  1  controller accepts vector this cycle
- s_data  in  N_INPUTS*DATA_WIDTH  unsorted vector, lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_desc  in  1  1 = deliver descending order
- s_tag  in  TAG_W  job tag, returned with result
- m_valid  out  1  sorted vector valid
- m_ready  in  1  downstream accepts
- m_data  out  N_INPUTS*DATA_WIDTH  sorted vector
- m_tag  out  TAG_W  tag of m_data
- bsn_en  out  1  BSN stage enable
- bsn_data_in  out  N_INPUTS*DATA_WIDTH  to BSN data_in
- bsn_data_out  in  N_INPUTS*DATA_WIDTH  from BSN data_out (ascending, lane 0 smallest)
- flush  in  1  request drain (level sampled in RUN)
- busy  out  1  any vector in flight or held on output
- flush_done  out  1  one-cycle pulse when drain completes
- done_cnt  out  16  completed output handshakes, wraps 0xFFFF->0

Behaviour:
- adv = !m_valid | m_ready; bsn_en = adv. Pipeline, sideband and output register move only when adv=1.
- s_ready = adv & (state==RUN). accept = s_valid & s_ready.
- bsn_data_in = s_data (combinational pass-through). When adv=1 and there is no accept, a bubble enters: sideband valid=0 and data don't-care.
- Sideband: LATENCY-entry shift register of {v, desc, tag}. On adv, entry 0 <= {accept, s_desc, s_tag}; entry k <= entry k-1.
- Output register, on adv:
  - m_valid <= sb[L-1].v; m_tag <= sb[L-1].tag.
  - m_data <= bsn_data_out, with lanes reversed (lane i <- lane N-1-i) if sb[L-1].desc.
  - When adv=0, all output register fields hold.
- Latency: accept at edge t yields m_valid=1 after edge t+LATENCY+1 (7 cycles by default). Throughput is 1 vector/cycle with m_ready held high. Order is strictly preserved; no skid buffer.
- busy = m_valid | OR of all sb[*].v.
- FSM has two states, RUN and DRAIN. Reset state is RUN.
  - RUN -> DRAIN when flush=1. Input is blocked from that cycle on (s_ready=0).
  - DRAIN -> RUN when busy=0. flush_done=1 on that cycle, combinationally from the state and busy.
  - If flush is still high on return to RUN, the FSM re-enters DRAIN the next cycle; the bench must pulse flush.
  - flush while idle: one DRAIN cycle, then flush_done.
- done_cnt increments on m_valid & m_ready. Wrap-around is natural modulo 2^16.
- Simultaneous case: the output consumed and a new input accepted in the same cycle is legal and is the normal streaming case.
- Reset values (asynchronous, effective mid-operation): all sb valids 0, m_valid 0, m_data 0, m_tag 0, done_cnt 0, state RUN.
  - In-flight vectors are discarded. The BSN's own rst must be tied to the same rst.
  - Outputs s_ready and bsn_en are 1 during and immediately after reset, because adv=1 and state is RUN.

Decomposition:
- Shared package bsn_pkg: DATA_WIDTH/N_INPUTS defaults, vector width constant, sideband struct {v, desc, tag}, FSM state enum {RUN, DRAIN}, lane-reverse function.
- One sub-module is natural: bsn_sideband_pipe, the parameterised LATENCY-deep enable-gated shift register of sideband entries, also exporting the OR-reduced valid.
- The BSN itself is instantiated next to the controller, not inside it.

Test Plan:
- Single vector: {8,7,6,5,4,3,2,1} (lane7..lane0 = 8..1 shuffled to {3,8,1,6,2,7,4,5}), desc=0, tag=5, m_ready=1 -> m_valid after exactly 7 cycles, lanes 0..7 = 1..8, m_tag=5, done_cnt=1.
- Descending: same vector with desc=1 -> lane 0..7 = 8..1.
- Streaming: 8 back-to-back vectors, tags 0..7, m_ready=1 -> 8 consecutive m_valid cycles, tags 0..7 in order, s_ready never low.
- Backpressure: during streaming, drop m_ready for 5 cycles.
  - bsn_en=0 and s_ready=0 during the stall.
  - m_data/m_tag stable during the stall.
  - No loss or duplication; tags stay in order.
- Flush: pulse flush with 3 vectors in flight -> s_ready=0 until drained, 3 results delivered, flush_done pulses once, busy=0, then input is accepted again.
- Reset mid-stream: assert rst with 4 vectors in flight -> m_valid=0 and busy=0 immediately; no stale result emerges over the next 10 cycles.
- Counter wrap: done_cnt goes 0xFFFF->0 on the next handshake.
